// File: rtl/prbs_checker_16.sv
// prbs_checker_16 -- receive-side PRBS checker for the 16-bit word link.
//
// Self-seeds a 32-bit LFSR from two received words. It then predicts every
// following word from its own LFSR, counts bit errors and tracks lock.
// The LFSR state s has s[0] as the newest bit. Each step computes
// b = ^(s & eqn) and sets s = {s[30:0], b}. The first predicted bit of a word
// lines up with din[15].
//
// Ports:
//   clk, rst         word clock; synchronous active-high reset
//   en               checker enable (0 -> IDLE, counters hold)
//   clr_cnt          synchronous clear of err_cnt / bit_cnt (wins over counting)
//   eqn[31:0]        LFSR tap mask
//   din[15:0]        received word, din[15] earliest; din_valid qualifies it
//   locked           high while in LOCKED
//   err_word         one-cycle pulse: last checked word had >=1 bit error
//   err_bits[4:0]    bit errors in last checked word (held between words)
//   err_cnt[31:0]    saturating accumulated bit errors (LOCKED only)
//   bit_cnt[47:0]    saturating accumulated checked bits (LOCKED only)
//   state[1:0]       0=IDLE 1=SEED 2=CHECK 3=LOCKED
//   inv_det          polarity flag, present only with PRBS_CHK_POLARITY_EN
//
// Optional build macro: PRBS_CHK_POLARITY_EN. It adds inverted-stream
// detection and the inv_det output.
module prbs_checker_16 #(
  parameter int LOCK_WORDS = 16,
  parameter int LOSS_BITS  = 8,
  parameter int LOSS_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr_cnt,
  input  logic [31:0] eqn,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        locked,
  output logic        err_word,
  output logic [4:0]  err_bits,
  output logic [31:0] err_cnt,
  output logic [47:0] bit_cnt,
`ifdef PRBS_CHK_POLARITY_EN
  output logic        inv_det,
`endif
  output logic [1:0]  state
);

  localparam int GW = $clog2(LOCK_WORDS + 1);
  localparam int BW = $clog2(LOSS_WORDS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, CHECK = 2'd2, LOCKED = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [31:0]   s_q, s_d;
  logic          seed_cnt_q, seed_cnt_d;   // valid seed words taken (0 or 1)
  logic [GW-1:0] good_cnt_q, good_cnt_d;   // consecutive clean words in CHECK
  logic [1:0]    errw_cnt_q, errw_cnt_d;   // errored words seen in this CHECK pass
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;     // consecutive bad words in LOCKED
  logic          locked_q, locked_d;
  logic          err_word_q, err_word_d;
  logic [4:0]    err_bits_q, err_bits_d;
  logic [31:0]   err_cnt_q, err_cnt_d;
  logic [47:0]   bit_cnt_q, bit_cnt_d;

  logic [15:0]   din_eff;
  logic [15:0]   pred;
  logic [31:0]   s_adv;
  logic [15:0]   diff;
  logic [4:0]    nerr;
  logic [32:0]   ec_sum;
  logic [48:0]   bc_sum;

`ifdef PRBS_CHK_POLARITY_EN
  logic          pol_q, pol_d;
  logic [GW-1:0] inv_cnt_q, inv_cnt_d;     // all-error words seen in CHECK
  // The inversion is applied before seeding as well as before comparison.
  // A re-seed then builds the LFSR from the true-polarity stream.
  assign din_eff = din ^ {16{pol_q}};
  assign inv_det = pol_q;
`else
  assign din_eff = din;
`endif

  // Run the LFSR 16 steps ahead on predicted bits only. A received bit error
  // therefore never enters the state.
  always_comb begin
    s_adv = s_q;
    pred  = '0;
    for (int i = 15; i >= 0; i--) begin
      pred[i] = ^(s_adv & eqn);
      s_adv   = {s_adv[30:0], pred[i]};
    end
  end

  assign diff = pred ^ din_eff;

  always_comb begin
    nerr = '0;
    for (int i = 0; i < 16; i++) nerr = nerr + 5'(diff[i]);
  end

  // The carry out of the widened sum selects saturation at all-ones.
  assign ec_sum = {1'b0, err_cnt_q} + 33'(nerr);
  assign bc_sum = {1'b0, bit_cnt_q} + 49'd16;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    seed_cnt_d = seed_cnt_q;
    good_cnt_d = good_cnt_q;
    errw_cnt_d = errw_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    locked_d   = locked_q;
    err_word_d = 1'b0;
    err_bits_d = err_bits_q;
    err_cnt_d  = err_cnt_q;
    bit_cnt_d  = bit_cnt_q;
`ifdef PRBS_CHK_POLARITY_EN
    pol_d      = pol_q;
    inv_cnt_d  = inv_cnt_q;
`endif

    if (!en) begin
      state_d  = IDLE;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = SEED;
          seed_cnt_d = 1'b0;
        end
        SEED: if (din_valid) begin
          s_d = {s_q[15:0], din_eff};
          if (seed_cnt_q) begin
            state_d    = CHECK;
            good_cnt_d = '0;
            errw_cnt_d = '0;
          end else begin
            seed_cnt_d = 1'b1;
          end
        end
        CHECK: if (din_valid) begin
          s_d        = s_adv;
          err_word_d = (nerr != 5'd0);
          err_bits_d = nerr;
          if (nerr == 5'd0) begin
            if (good_cnt_q == GW'(LOCK_WORDS - 1)) begin
              state_d   = LOCKED;
              locked_d  = 1'b1;
              bad_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else begin
            good_cnt_d = '0;
            if (errw_cnt_q == 2'd2) begin
              state_d    = SEED;
              seed_cnt_d = 1'b0;
            end else begin
              errw_cnt_d = errw_cnt_q + 1'b1;
            end
          end
`ifdef PRBS_CHK_POLARITY_EN
          // This counter persists across SEED/CHECK passes. An inverted stream
          // re-seeds every few words, so the all-error words accumulate.
          if (nerr == 5'd16) begin
            if (inv_cnt_q == GW'(LOCK_WORDS - 1)) begin
              inv_cnt_d  = '0;
              pol_d      = ~pol_q;
              state_d    = SEED;
              seed_cnt_d = 1'b0;
            end else begin
              inv_cnt_d = inv_cnt_q + 1'b1;
            end
          end else begin
            inv_cnt_d = '0;
          end
`endif
        end
        LOCKED: if (din_valid) begin
          s_d        = s_adv;
          err_word_d = (nerr != 5'd0);
          err_bits_d = nerr;
          err_cnt_d  = ec_sum[32] ? '1 : ec_sum[31:0];
          bit_cnt_d  = bc_sum[48] ? '1 : bc_sum[47:0];
          if (nerr >= 5'(LOSS_BITS)) begin
            if (bad_cnt_q == BW'(LOSS_WORDS - 1)) begin
              state_d    = SEED;
              locked_d   = 1'b0;
              seed_cnt_d = 1'b0;
              bad_cnt_d  = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      seed_cnt_q <= 1'b0;
      good_cnt_q <= '0;
      errw_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
      err_word_q <= 1'b0;
      err_bits_q <= '0;
      err_cnt_q  <= '0;
      bit_cnt_q  <= '0;
`ifdef PRBS_CHK_POLARITY_EN
      pol_q      <= 1'b0;
      inv_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      seed_cnt_q <= seed_cnt_d;
      good_cnt_q <= good_cnt_d;
      errw_cnt_q <= errw_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      locked_q   <= locked_d;
      err_word_q <= err_word_d;
      err_bits_q <= err_bits_d;
      err_cnt_q  <= err_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
`ifdef PRBS_CHK_POLARITY_EN
      pol_q      <= pol_d;
      inv_cnt_q  <= inv_cnt_d;
`endif
    end
  end

  assign state    = state_q;
  assign locked   = locked_q;
  assign err_word = err_word_q;
  assign err_bits = err_bits_q;
  assign err_cnt  = err_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: doc/prbs_checker_16.md
Name: prbs_checker_16

Overview:
- Receive-side PRBS checker for the serial link whose transmit side is our 16-lane PRBS generator and 16:4:1 mux chain.
- Consumes 16-bit deserialized words and self-seeds its LFSR from the incoming stream.
- Then predicts each following word, counts bit errors, and reports lock status.
- Sits after the RX deserializer, in the same clock domain as the word clock.

Parameters:
- LOCK_WORDS, 16: consecutive error-free words needed to declare lock.
- LOSS_BITS, 8: bit errors in one word that mark it "bad" while locked.
- LOSS_WORDS, 4: consecutive bad words that drop lock and force a reseed.

Ports:
- clk  in  1  word clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  checker enable
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt
- eqn  in  32  LFSR tap mask; same format as the generator's eqn input
- din  in  16  received word; din[15] is the earliest serial bit
- din_valid  in  1  din is valid this cycle
- locked  out  1  checker is in LOCKED
- err_word  out  1  one-cycle pulse: the last checked word had at least one bit error
- err_bits  out  5  number of bit errors in the last checked word (0..16)
- err_cnt  out  32  accumulated bit errors, saturating
- bit_cnt  out  48  accumulated bits checked, saturating
- state  out  2  0=IDLE, 1=SEED, 2=CHECK, 3=LOCKED

Behaviour:
- LFSR model: 32-bit state s; s[0] is the newest bit.
  - Next bit b = XOR-reduce(s & eqn); then s <= {s[30:0], b}.
  - One word = 16 successive steps; the first predicted bit is compared to din[15].
- Reset: state=IDLE; locked=0; err_word=0; err_bits=0; err_cnt=0; bit_cnt=0; s=0.
- IDLE:
  - Stays here while en=0. Counters hold their values.
  - en=1 -> SEED, with the seed-word counter cleared.
- SEED:
  - Each valid word shifts into s: s <= {s[15:0], din}, MSB-first.
  - After 2 valid words -> CHECK, with the good-word counter cleared.
- CHECK and LOCKED:
  - Each valid word is compared against the predicted word.
  - s advances from predicted bits only, never from received bits, so one error does not propagate.
  - err_bits = popcount(predicted XOR din).
- CHECK transitions:
  - err_bits==0: good-word counter increments. On reaching LOCK_WORDS -> LOCKED, with locked=1 in the same cycle.
  - Any error: good-word counter clears to 0.
  - More than 2 errored words before lock -> SEED.
- LOCKED:
  - err_cnt += err_bits and bit_cnt += 16 on every valid word.
  - Both saturate at all-ones and never wrap.
  - err_bits >= LOSS_BITS increments the bad-word counter; any other word clears it.
  - Bad-word counter reaching LOSS_WORDS -> SEED with locked=0. The counters keep their values.
- Outputs are registered: err_word, err_bits, counter updates and locked all appear 1 cycle after the din_valid cycle.
- err_word and err_bits update in both CHECK and LOCKED. err_bits holds its value between valid words.
- din_valid=0: no state advance, no counting, err_word=0.
- en=0 in any state -> IDLE on the next edge; locked=0; counters hold.
- clr_cnt=1: err_cnt=0 and bit_cnt=0 on the next edge.
  - If a counted word arrives in the same cycle, clear wins and that word is not counted.
- rst has priority over everything. Reset mid-check returns to IDLE with all outputs at their reset values.

Optional Feature:
- Macro: PRBS_CHK_POLARITY_EN.
- Defined: in CHECK, a word with err_bits==16 increments a separate invert-counter.
  - Reaching LOCK_WORDS toggles an internal polarity flag; from then on din is XOR-ed with 16'hFFFF before comparison, then the checker -> SEED.
  - This lets the checker lock on the inverted (N-side) path.
  - The flag clears on rst. It is exposed as an extra 1-bit output port inv_det.
- Undefined: no inversion, no inv_det port. An inverted stream never locks; it cycles SEED -> CHECK.

Test Plan:
- Clean lock: eqn=32'h100002; drive a generator seeded 32'h0ffd4066 at 1 word/cycle with en=1 -> SEED lasts 2 words, locked=1 exactly after LOCK_WORDS=16 clean words. After 1000 locked words: bit_cnt=16000, err_cnt=0.
- Single-bit error: flip din[7] in one word while locked -> err_word pulses once, err_bits=1, err_cnt=1. The following words have 0 errors (no propagation) and locked stays 1.
- Loss of lock: replace 4 consecutive words with random data (>=8 bit errors each) -> state goes to SEED after the 4th; the clean stream afterwards relocks after 2+16 words.
- Saturation and clear: force err_cnt near 32'hFFFFFFF0 and inject 16-bit error words -> holds at 32'hFFFFFFFF. Assert clr_cnt together with an errored word -> err_cnt=0.
- Gaps and control: toggle din_valid 50% -> lock timing counts valid words only. Assert rst mid-LOCKED -> IDLE, all outputs 0 on the next cycle. en=0 -> IDLE with counters held.
- With PRBS_CHK_POLARITY_EN: feed the inverted stream -> inv_det=1 after 16 all-error words, then locked=1 after 2+16 further words.
